// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: synchronous clear/set/load plus a sequenced
// one-bit-per-clock shift/rotate engine with a start/busy/done handshake.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             set,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  input  logic             dir,
  input  logic             rotate,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_q;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dir;
  logic               r_rot;

  state_t             w_state_nx;
  logic [WIDTH-1:0]   w_q_nx;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic               w_dir_nx;
  logic               w_rot_nx;
  logic               w_fill;
  logic [WIDTH-1:0]   w_shifted;

  // Rotate refills with the bit being expelled; plain shift takes sin live.
  assign w_fill    = r_rot ? (r_dir ? r_q[WIDTH-1] : r_q[0]) : sin;
  assign w_shifted = r_dir ? {r_q[WIDTH-2:0], w_fill} : {w_fill, r_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    w_state_nx = r_state;
    w_q_nx     = r_q;
    w_cnt_nx   = r_cnt;
    w_dir_nx   = r_dir;
    w_rot_nx   = r_rot;
    case (r_state)
      S_SHIFT: begin
        if (clr) begin
          w_q_nx     = '0;
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
        end else if (set) begin
          w_q_nx     = '1;
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
        end else begin
          w_q_nx   = w_shifted;
          w_cnt_nx = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nx = S_DONE;
        end
      end
      default: begin
        // IDLE and DONE share the same command decode; DONE always exits.
        w_state_nx = S_IDLE;
        if (clr) begin
          w_q_nx = '0;
        end else if (set) begin
          w_q_nx = '1;
        end else if (load) begin
          w_q_nx = d;
        end else if (start) begin
          w_dir_nx   = dir;
          w_rot_nx   = rotate;
          w_cnt_nx   = amt;
          w_state_nx = (amt == '0) ? S_DONE : S_SHIFT;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_rot   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_q     <= w_q_nx;
      r_cnt   <= w_cnt_nx;
      r_dir   <= w_dir_nx;
      r_rot   <= w_rot_nx;
    end
  end

  assign q    = r_q;
  assign sout = r_dir ? r_q[WIDTH-1] : r_q[0];
  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8) with hand-computed
// expected values; inputs change and outputs are sampled 1 time unit after posedge.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             clr, set, load, start, dir, rotate, sin;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] q;
  logic             sout, busy, done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .clr(clr), .set(set), .load(load), .d(d),
    .start(start), .amt(amt), .dir(dir), .rotate(rotate), .sin(sin),
    .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    d = v; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start(input logic di, input logic ro, input logic [CNT_W-1:0] n);
    dir = di; rotate = ro; amt = n; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr = 0; set = 0; load = 0; start = 0; dir = 0; rotate = 0;
    sin = 0; d = '0; amt = '0;
    repeat (2) cyc();
    check("rst_q", q, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sout", sout, 0);
    reset = 1'b0;
    cyc();

    // Rotate right by 3: A5 -> D2 -> 69 -> B4
    do_load(8'hA5);
    check("ldA5_q", q, 8'hA5);
    do_start(1'b0, 1'b1, 3);
    check("rr_busy0", busy, 1); check("rr_done0", done, 0);
    cyc(); check("rr_q1", q, 8'hD2); check("rr_busy1", busy, 1);
    cyc(); check("rr_q2", q, 8'h69); check("rr_busy2", busy, 1);
    cyc(); check("rr_q3", q, 8'hB4); check("rr_busy3", busy, 0); check("rr_done3", done, 1);
    cyc(); check("rr_done_end", done, 0); check("rr_q_end", q, 8'hB4);

    // Shift left by 4 with sin 1,0,1,1: 81 -> 03 -> 06 -> 0D -> 1B
    do_load(8'h81);
    do_start(1'b1, 1'b0, 4);
    check("sl_sout", sout, 1); check("sl_busy", busy, 1); check("sl_q0", q, 8'h81);
    sin = 1; cyc(); check("sl_q1", q, 8'h03);
    sin = 0; cyc(); check("sl_q2", q, 8'h06);
    sin = 1; cyc(); check("sl_q3", q, 8'h0D);
    sin = 1; cyc(); check("sl_q4", q, 8'h1B); check("sl_done", done, 1); check("sl_busy4", busy, 0);
    sin = 0; cyc(); check("sl_done_end", done, 0);

    // amt = 0: straight to DONE, q unchanged, busy never rises
    do_load(8'h3C);
    do_start(1'b0, 1'b0, 0);
    check("z_busy", busy, 0); check("z_done", done, 1); check("z_q", q, 8'h3C);
    cyc(); check("z_done_end", done, 0); check("z_busy_end", busy, 0); check("z_q_end", q, 8'h3C);

    // Abort with set on the 3rd shift edge; load/start in SHIFT are ignored
    do_load(8'h0F);
    sin = 0;
    do_start(1'b1, 1'b0, 6);
    check("ab_busy", busy, 1);
    d = 8'h55; load = 1; start = 1; amt = 1;
    cyc();
    load = 0; start = 0;
    check("ab_q1", q, 8'h1E); check("ab_busy1", busy, 1);
    cyc(); check("ab_q2", q, 8'h3C);
    set = 1; cyc(); set = 0;
    check("ab_q_set", q, 8'hFF); check("ab_busy_set", busy, 0); check("ab_done_set", done, 0);
    cyc(); check("ab_done_a", done, 0); check("ab_q_hold", q, 8'hFF);
    cyc(); check("ab_done_b", done, 0);

    // clr and set together: clear wins
    do_load(8'h5A);
    clr = 1; set = 1; cyc(); clr = 0; set = 0;
    check("clrset_q", q, 8'h00);

    // Back-to-back: rotate left 1 (5A -> B4), start again in DONE cycle
    do_load(8'h5A);
    do_start(1'b1, 1'b1, 1);
    check("bb_busy", busy, 1);
    cyc(); check("bb_q1", q, 8'hB4); check("bb_done1", done, 1);
    sin = 1;
    do_start(1'b0, 1'b0, 2);
    check("bb2_busy", busy, 1); check("bb2_done", done, 0); check("bb2_q", q, 8'hB4);
    cyc(); check("bb2_q1", q, 8'hDA);
    cyc(); check("bb2_q2", q, 8'hED); check("bb2_done2", done, 1);
    sin = 0; cyc();

    // Async reset mid-sequence (amt=5, after 2 shifts: F0 -> F8 -> FC)
    do_load(8'hF0);
    sin = 1;
    do_start(1'b0, 1'b0, 5);
    cyc(); cyc();
    check("mr_q_pre", q, 8'hFC); check("mr_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mr_q", q, 8'h00); check("mr_busy", busy, 0);
    check("mr_done", done, 0); check("mr_sout", sout, 0);
    reset = 1'b0; sin = 0;
    cyc();
    do_load(8'h01);
    do_start(1'b1, 1'b0, 1);
    check("mr2_busy", busy, 1);
    cyc(); check("mr2_q", q, 8'h02); check("mr2_done", done, 1);
    cyc();

    // amt > WIDTH with rotate: 9 rotations left of 01 == rotate by 1
    do_load(8'h01);
    do_start(1'b1, 1'b1, 9);
    repeat (8) cyc();
    check("big_q8", q, 8'h01); check("big_busy8", busy, 1);
    cyc(); check("big_q9", q, 8'h02); check("big_done", done, 1);
    cyc(); check("big_done_end", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
